// File: rtl/kf8237_common_pkg.sv
// kf8237_common_pkg: channel count and shared register types for the KF8237 DMA register file
package kf8237_common_pkg;
  localparam int NUM_CHANNELS = 4;
  typedef logic [15:0] word16_t;
  typedef logic [NUM_CHANNELS-1:0] channel_onehot_t;
endpackage

// File: rtl/kf8237_channel_register_pair.sv
// kf8237_channel_register_pair: base+current 16-bit pair with byte-lane load, +/-1 step, reload-from-base and high-byte-change flag
module kf8237_channel_register_pair
  import kf8237_common_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       write_low,
  input  logic       write_high,
  input  logic       step,
  input  logic       decrement,
  input  logic       reload,
  output word16_t    current,
  output logic       high_change
);
  word16_t base;
  word16_t moved;
  word16_t stepped;
  assign moved = reload ? base : decrement ? current - 16'd1 : current + 16'd1;
  assign stepped = (step || reload) ? moved : current;
  assign high_change = (step || reload) && (moved[15:8] != current[15:8]);
  always_ff @(posedge clock)
    if (reset) begin
      base <= '0;
      current <= '0;
    end else begin
      base <= {write_high ? data : base[15:8], write_low ? data : base[7:0]};
      current <= {write_high ? data : stepped[15:8], write_low ? data : stepped[7:0]};
    end
endmodule

// File: rtl/kf8237_address_and_count_registers.sv
// kf8237_address_and_count_registers: per-channel address/count registers, byte-pointer read-back and transfer stepping
module kf8237_address_and_count_registers
  import kf8237_common_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  internal_data_bus,
  input  logic [3:0]  write_base_and_current_address,
  input  logic [3:0]  write_base_and_current_word_count,
  input  logic [3:0]  read_current_address,
  input  logic [3:0]  read_current_word_count,
  input  logic        clear_byte_pointer,
  input  logic        master_clear,
  input  logic [3:0]  dma_select,
  input  logic        next_word,
  input  logic        address_hold_config,
  input  logic        decrement_address_config,
  input  logic        autoinitialize_config,
  output logic [7:0]  read_address_or_count,
  output logic [15:0] transfer_address,
  output logic        terminal_count,
  output logic        update_high_address
);
  word16_t register_file [2*NUM_CHANNELS];
  logic high_change [2*NUM_CHANNELS];
  logic [2*NUM_CHANNELS-1:0] write_strobe;
  logic [2*NUM_CHANNELS-1:0] read_strobe;
  channel_onehot_t zero_count;
  channel_onehot_t reload_channel;
  channel_onehot_t step_channel;
  word16_t selected_address;
  word16_t read_word;
  logic valid_select;
  logic advance;
  logic read_active;
  logic read_active_d;
  logic byte_pointer;
  logic address_high_change;
  assign write_strobe = {write_base_and_current_word_count, write_base_and_current_address};
  assign read_strobe = {read_current_word_count, read_current_address};
  assign read_active = |read_strobe;
  assign valid_select = $onehot(dma_select);
  assign advance = next_word && valid_select;
  assign reload_channel = advance ? dma_select & zero_count & {NUM_CHANNELS{autoinitialize_config}} : '0;
  assign step_channel = advance ? dma_select & ~reload_channel : '0;
  for (genvar k = 0; k < 2*NUM_CHANNELS; k++) begin : g_pair
    localparam int c = k % NUM_CHANNELS;
    localparam bit is_count = k >= NUM_CHANNELS;
    kf8237_channel_register_pair u_pair (
      .clock(clock),
      .reset(reset),
      .data(internal_data_bus),
      .write_low(write_strobe[k] && !byte_pointer),
      .write_high(write_strobe[k] && byte_pointer),
      .step(step_channel[c] && (is_count || !address_hold_config)),
      .decrement(is_count || decrement_address_config),
      .reload(reload_channel[c]),
      .current(register_file[k]),
      .high_change(high_change[k])
    );
  end
  always_comb begin
    zero_count = '0;
    selected_address = '0;
    address_high_change = 1'b0;
    read_word = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      zero_count[i] = register_file[NUM_CHANNELS+i] == 16'h0000;
      address_high_change = address_high_change | high_change[i];
      if (dma_select[i]) selected_address = register_file[i];
    end
    for (int i = 0; i < 2*NUM_CHANNELS; i++)
      if (read_strobe[i]) read_word = register_file[i];
  end
  assign read_address_or_count = !$onehot(read_strobe) ? 8'h00 : byte_pointer ? read_word[15:8] : read_word[7:0];
  assign transfer_address = valid_select ? selected_address : 16'h0000;
  assign terminal_count = valid_select && |(dma_select & zero_count);
  always_ff @(posedge clock)
    if (reset) begin
      byte_pointer <= 1'b0;
      read_active_d <= 1'b0;
      update_high_address <= 1'b0;
    end else begin
      byte_pointer <= (clear_byte_pointer || master_clear) ? 1'b0 :
                      (|write_strobe || (read_active_d && !read_active)) ? !byte_pointer : byte_pointer;
      read_active_d <= read_active;
      update_high_address <= address_high_change;
    end
endmodule

// File: doc/kf8237_address_and_count_registers.md
Name: kf8237_address_and_count_registers

Overview:
Register file for the four KF8237 DMA channels. It consumes the decoded register strobes and internal data bus from the bus control logic, and holds the base/current address and base/current word count for each channel. It returns CPU read-back bytes through the byte-pointer flip-flop. During transfers it advances the active channel's current address and count, and flags terminal count and high-address-byte changes to the timing/control stage.

Parameters:
none (channel count fixed at 4; register width fixed at 16)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
internal_data_bus  in  8  write data from bus control logic
write_base_and_current_address  in  4  one-hot per channel, 1-cycle pulse
write_base_and_current_word_count  in  4  one-hot per channel, 1-cycle pulse
read_current_address  in  4  per channel, level while CPU read active
read_current_word_count  in  4  per channel, level while CPU read active
clear_byte_pointer  in  1  1-cycle pulse
master_clear  in  1  1-cycle pulse
dma_select  in  4  one-hot active channel from priority logic
next_word  in  1  1-cycle pulse: advance the selected channel
address_hold_config  in  1  selected channel's mode: hold address
decrement_address_config  in  1  selected channel's mode: 1 = decrement, 0 = increment
autoinitialize_config  in  1  selected channel's mode: autoinit
read_address_or_count  out  8  CPU read-back byte
transfer_address  out  16  current address of the selected channel
terminal_count  out  1  selected channel's current count == 16'h0000
update_high_address  out  1  1-cycle pulse: high address byte changed

Behaviour:
- Reset (synchronous): all base/current registers = 16'h0000; byte_pointer = 0; update_high_address = 0.
- master_clear or clear_byte_pointer: byte_pointer = 0 next edge. Registers are retained.
- CPU write pulse to channel n:
  - byte_pointer = 0 → low byte of base and current loaded with internal_data_bus.
  - byte_pointer = 1 → high byte loaded.
  - byte_pointer toggles on the same edge.
- CPU read:
  - read_address_or_count is combinational: the selected current register's low byte (pointer = 0) or high byte (pointer = 1).
  - With no read strobe, or more than one strobe active, it drives 8'h00.
  - byte_pointer toggles one cycle after the OR of all read strobes falls (edge detect, registered).
- Clear versus toggle in the same cycle: clear wins.
- next_word with one-hot dma_select = n:
  - Address: if !address_hold_config, current_address[n] ±1 mod 2^16 (FFFF+1 → 0000, 0000−1 → FFFF).
  - Count: current_word_count[n] −1 mod 2^16.
  - Autoinitialize: if current_word_count[n] == 0 before the update and autoinitialize_config = 1, both currents reload from their bases instead.
- dma_select not one-hot (zero or multiple bits): next_word is ignored; transfer_address = 16'h0000; terminal_count = 0.
- terminal_count is combinational from the selected channel's current count. Timing control samples it together with next_word to end the service.
- update_high_address is registered. It pulses one cycle after a next_word whose address step changed bits [15:8]; an autoinit reload counts as a change if the high byte differs. Otherwise it is 0.
- CPU write and next_word to the same channel in the same cycle: the written byte takes the CPU value; the other byte takes the stepped value.
- Reset mid-transfer: state clears immediately and no pulse is emitted.
- Latency: register updates take effect at the next edge. Read-back and transfer_address reflect the new value one cycle after the write/step.

Decomposition:
- Shared package kf8237_common_pkg:
  - constant NUM_CHANNELS = 4
  - typedef word16_t (logic [15:0])
  - typedef channel_onehot_t (logic [3:0])
- Sub-module kf8237_channel_register_pair:
  - one instance per register kind (address/count) per channel, i.e. 8 instances
  - holds base plus current
  - byte-lane load, ±1 step, reload-from-base, and a carry-into-high-byte flag
- The top level holds byte_pointer, the read mux, the select mux, and update_high_address.

Test Plan:
- Write ch0 address bytes 8'h34 then 8'h12; pulse read_current_address[0] twice → read-back 8'h34 then 8'h12; byte_pointer returns to 0.
- Write a low byte 8'hAA, pulse clear_byte_pointer, write 8'hBB → ch1 address low byte = 8'hBB, high byte unchanged 8'h00.
- Ch2 address 16'h00FF, increment mode; pulse next_word → transfer_address = 16'h0100, update_high_address pulses once. With hold mode set, the address stays 16'h00FF.
- Ch3 count 16'h0001 with base 16'h0005, autoinit = 1:
  - after the first next_word, count = 0 and terminal_count = 1;
  - the second next_word reloads count to 16'h0005 and the address to its base.
  - With autoinit = 0, count wraps to 16'hFFFF.
- Decrement mode, address 16'h0000 → 16'hFFFF with an update_high_address pulse. dma_select = 4'b0011 with next_word → no register changes.
- Assert reset mid-sequence after programming all channels → all reads return 8'h00, terminal_count = 1 for the selected channel (count 0), byte_pointer = 0.
